// File: rtl/axi4_lite_master_arbiter.sv
// axi4_lite_master_arbiter: round-robin sharing of one AXI4-Lite master port among NUM_REQ requesters
module axi4_lite_master_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_rdata,
  output logic                             resp_err,
  output logic [ADDR_WIDTH-1:0]            awaddr,
  output logic                             awvalid,
  input  logic                             awready,
  output logic [DATA_WIDTH-1:0]            wdata,
  output logic                             wvalid,
  input  logic                             wready,
  input  logic [1:0]                       bresp,
  input  logic                             bvalid,
  output logic                             bready,
  output logic [ADDR_WIDTH-1:0]            araddr,
  output logic                             arvalid,
  input  logic                             arready,
  input  logic [DATA_WIDTH-1:0]            rdata,
  input  logic [1:0]                       rresp,
  input  logic                             rvalid,
  output logic                             rready
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [2:0] {IDLE, WRITE, WRITE_RESP, READ_ADDR, READ_DATA, DONE} state_t;
  state_t state, state_d;
  logic [IW-1:0] rr, idx, gnt, p;
  logic gnt_any, aw_left, w_left;
  int j;
  // scan from the highest offset down so the first valid at or after rr wins
  always_comb begin
    gnt = '0;
    gnt_any = 1'b0;
    j = 0;
    p = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr) + k;
      j = (j >= NUM_REQ) ? j - NUM_REQ : j;
      p = IW'(j);
      if (req_valid[p]) begin
        gnt = p;
        gnt_any = 1'b1;
      end
    end
  end
  assign req_ready = (state == IDLE && gnt_any) ? NUM_REQ'(1) << gnt : '0;
  assign aw_left = awvalid & ~awready;
  assign w_left = wvalid & ~wready;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:       state_d = gnt_any ? (req_write[gnt] ? WRITE : READ_ADDR) : IDLE;
      WRITE:      state_d = (!aw_left && !w_left) ? WRITE_RESP : WRITE;
      WRITE_RESP: state_d = bvalid ? DONE : WRITE_RESP;
      READ_ADDR:  state_d = arready ? READ_DATA : READ_ADDR;
      READ_DATA:  state_d = rvalid ? DONE : READ_DATA;
      default:    state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr <= '0;
      idx <= '0;
      awaddr <= '0;
      awvalid <= 1'b0;
      wdata <= '0;
      wvalid <= 1'b0;
      bready <= 1'b0;
      araddr <= '0;
      arvalid <= 1'b0;
      rready <= 1'b0;
      resp_valid <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      resp_valid <= '0;
      case (state)
        IDLE: if (gnt_any) begin
          idx <= gnt;
          rr <= (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
          if (req_write[gnt]) begin
            awaddr <= req_addr[gnt*ADDR_WIDTH +: ADDR_WIDTH];
            wdata <= req_wdata[gnt*DATA_WIDTH +: DATA_WIDTH];
            awvalid <= 1'b1;
            wvalid <= 1'b1;
          end else begin
            araddr <= req_addr[gnt*ADDR_WIDTH +: ADDR_WIDTH];
            arvalid <= 1'b1;
          end
        end
        WRITE: begin
          if (awready) awvalid <= 1'b0;
          if (wready) wvalid <= 1'b0;
          if (!aw_left && !w_left) bready <= 1'b1;
        end
        WRITE_RESP: if (bvalid) begin
          bready <= 1'b0;
          resp_valid <= NUM_REQ'(1) << idx;
          resp_rdata <= '0;
          resp_err <= bresp[1];
        end
        READ_ADDR: if (arready) begin
          arvalid <= 1'b0;
          rready <= 1'b1;
        end
        READ_DATA: if (rvalid) begin
          rready <= 1'b0;
          resp_valid <= NUM_REQ'(1) << idx;
          resp_rdata <= rdata;
          resp_err <= rresp[1];
        end
        default: ;
      endcase
    end
  end
endmodule
